// File: rtl/dcache_state_ctrl_pkg.sv
// Shared encodings for the data-cache state array sequencer.
// State entry layout: bit1 = dirty, bit0 = valid.
package dcache_state_ctrl_pkg;

    typedef enum logic [1:0] {
        DC_OP_FILL  = 2'b00,
        DC_OP_MARK  = 2'b01,
        DC_OP_INVAL = 2'b10,
        DC_OP_FLUSH = 2'b11
    } dc_op_e;

    localparam int DC_ST_DIRTY = 1;
    localparam int DC_ST_VALID = 0;

    localparam logic [1:0] DC_ST_I  = 2'b00;
    localparam logic [1:0] DC_ST_V  = 2'b01;
    localparam logic [1:0] DC_ST_DV = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WRITE,
        ST_FL_RD,
        ST_FL_WB,
        ST_FL_WR
    } dc_state_e;

    function automatic logic st_dirty_valid(input logic [1:0] st);
        return st[DC_ST_DIRTY] & st[DC_ST_VALID];
    endfunction

endpackage

// File: rtl/dcache_victim_sel.sv
// Victim choice inside one two-way partition: lowest invalid way first,
// otherwise the way named by the partition's round-robin bit.
module dcache_victim_sel
    import dcache_state_ctrl_pkg::*;
(
    input  logic [1:0] st_lo,
    input  logic [1:0] st_hi,
    input  logic       sec,
    input  logic       rr,
    output logic [1:0] way,
    output logic       evict
);

    logic [1:0] w_rr_st;

    always_comb begin
        w_rr_st = rr ? st_hi : st_lo;
        way     = {sec, rr};
        evict   = 1'b0;
        if (!st_lo[DC_ST_VALID]) begin
            way = {sec, 1'b0};
        end else if (!st_hi[DC_ST_VALID]) begin
            way = {sec, 1'b1};
        end else begin
            evict = st_dirty_valid(w_rr_st);
        end
    end

endmodule

// File: rtl/dcache_state_ctrl.sv
// Sequencer for the 4-way dcache dirty/valid array: fill with partitioned
// victim choice, mark-dirty, invalidate, and per-partition flush with writeback.
`ifndef D_INDEX_WIDTH
`define D_INDEX_WIDTH 6
`endif

module dcache_state_ctrl
    import dcache_state_ctrl_pkg::*;
#(
    parameter int IW   = `D_INDEX_WIDTH,
    parameter int NSET = 1 << IW
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic          req_sec,
    input  logic [IW-1:0] req_index,
    input  logic [1:0]    req_way,
    output logic          resp_valid,
    output logic [1:0]    resp_way,
    output logic          resp_evict,
    output logic          wb_valid,
    input  logic          wb_ready,
    output logic [IW-1:0] wb_index,
    output logic [1:0]    wb_way,
    output logic [IW-1:0] st_index,
    output logic [1:0]    st_way,
    output logic [1:0]    st_din,
    output logic          st_we,
    output logic          st_en,
    input  logic [1:0]    st_dout0,
    input  logic [1:0]    st_dout1,
    input  logic [1:0]    st_dout2,
    input  logic [1:0]    st_dout3
);

    dc_state_e     r_state;
    logic          r_sec;
    logic [1:0]    r_rr;
    logic [IW-1:0] r_fidx;
    logic          r_fway;

    logic          r_resp_valid;
    logic [1:0]    r_resp_way;
    logic          r_resp_evict;
    logic          r_wb_valid;
    logic [IW-1:0] r_wb_index;
    logic [1:0]    r_wb_way;
    logic [IW-1:0] r_st_index;
    logic [1:0]    r_st_way;
    logic [1:0]    r_st_din;
    logic          r_st_we;
    logic          r_st_en;

    logic [1:0]    w_lo;
    logic [1:0]    w_hi;
    logic [1:0]    w_rd;
    logic          w_full;
    logic          w_fl_last;
    logic [IW-1:0] w_fidx_nxt;
    logic          w_fway_nxt;
    logic [1:0]    w_vway;
    logic          w_vevict;

    // Only the latched partition's two ways are ever looked at.
    always_comb begin
        w_lo       = r_sec ? st_dout2 : st_dout0;
        w_hi       = r_sec ? st_dout3 : st_dout1;
        w_rd       = r_fway ? w_hi : w_lo;
        w_full     = w_lo[DC_ST_VALID] & w_hi[DC_ST_VALID];
        w_fl_last  = (r_fidx == IW'(NSET - 1)) && r_fway;
        w_fway_nxt = ~r_fway;
        w_fidx_nxt = r_fway ? r_fidx + IW'(1) : r_fidx;
    end

    dcache_victim_sel u_victim (
        .st_lo (w_lo),
        .st_hi (w_hi),
        .sec   (r_sec),
        .rr    (r_rr[r_sec]),
        .way   (w_vway),
        .evict (w_vevict)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_sec        <= 1'b0;
            r_rr         <= '0;
            r_fidx       <= '0;
            r_fway       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_way   <= '0;
            r_resp_evict <= 1'b0;
            r_wb_valid   <= 1'b0;
            r_wb_index   <= '0;
            r_wb_way     <= '0;
            r_st_index   <= '0;
            r_st_way     <= '0;
            r_st_din     <= '0;
            r_st_we      <= 1'b0;
            r_st_en      <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            r_st_we      <= 1'b0;
            r_st_en      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_sec      <= req_sec;
                        r_st_index <= req_index;
                        r_st_en    <= 1'b1;
                        case (req_op)
                            DC_OP_FILL: begin
                                r_state  <= ST_LOOKUP;
                                r_st_way <= {req_sec, 1'b0};
                            end
                            DC_OP_MARK, DC_OP_INVAL: begin
                                // A way outside the requester's partition is silently not written.
                                r_state      <= ST_WRITE;
                                r_st_way     <= req_way;
                                r_st_din     <= (req_op == DC_OP_MARK) ? DC_ST_DV : DC_ST_I;
                                r_st_we      <= (req_way[1] == req_sec);
                                r_resp_valid <= 1'b1;
                            end
                            default: begin
                                r_state    <= ST_FL_RD;
                                r_fidx     <= '0;
                                r_fway     <= 1'b0;
                                r_st_index <= '0;
                                r_st_way   <= {req_sec, 1'b0};
                            end
                        endcase
                    end
                end
                ST_LOOKUP: begin
                    r_state      <= ST_WRITE;
                    r_st_en      <= 1'b1;
                    r_st_we      <= 1'b1;
                    r_st_way     <= w_vway;
                    r_st_din     <= DC_ST_V;
                    r_resp_valid <= 1'b1;
                    r_resp_way   <= w_vway;
                    r_resp_evict <= w_vevict;
                    if (w_full) begin
                        r_rr[r_sec] <= ~r_rr[r_sec];
                    end
                end
                ST_WRITE: begin
                    r_state <= ST_IDLE;
                end
                ST_FL_RD: begin
                    if (st_dirty_valid(w_rd)) begin
                        r_state    <= ST_FL_WB;
                        r_wb_valid <= 1'b1;
                        r_wb_index <= r_fidx;
                        r_wb_way   <= r_st_way;
                    end else begin
                        r_state      <= ST_FL_WR;
                        r_st_en      <= 1'b1;
                        r_st_we      <= 1'b1;
                        r_st_din     <= DC_ST_I;
                        r_resp_valid <= w_fl_last;
                    end
                end
                ST_FL_WB: begin
                    if (wb_ready) begin
                        r_wb_valid   <= 1'b0;
                        r_state      <= ST_FL_WR;
                        r_st_en      <= 1'b1;
                        r_st_we      <= 1'b1;
                        r_st_din     <= DC_ST_I;
                        r_resp_valid <= w_fl_last;
                    end
                end
                ST_FL_WR: begin
                    if (w_fl_last) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state    <= ST_FL_RD;
                        r_fidx     <= w_fidx_nxt;
                        r_fway     <= w_fway_nxt;
                        r_st_en    <= 1'b1;
                        r_st_index <= w_fidx_nxt;
                        r_st_way   <= {r_sec, w_fway_nxt};
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (r_state == ST_IDLE) && !rst;
    assign resp_valid = r_resp_valid;
    assign resp_way   = r_resp_way;
    assign resp_evict = r_resp_evict;
    assign wb_valid   = r_wb_valid;
    assign wb_index   = r_wb_index;
    assign wb_way     = r_wb_way;
    assign st_index   = r_st_index;
    assign st_way     = r_st_way;
    assign st_din     = r_st_din;
    assign st_we      = r_st_we;
    assign st_en      = r_st_en;

endmodule

// File: tb/tb_dcache_state_ctrl.sv
// Bench for dcache_state_ctrl: behavioural state array plus an operation-level
// reference model of contents, round-robin pointers, latency and writebacks.
`timescale 1ns/1ps

module tb_dcache_state_ctrl;

    localparam int IW     = 2;
    localparam int NSET   = 4;
    localparam int BUDGET = 300;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic          req_sec;
    logic [IW-1:0] req_index;
    logic [1:0]    req_way;
    logic          resp_valid;
    logic [1:0]    resp_way;
    logic          resp_evict;
    logic          wb_valid;
    logic          wb_ready;
    logic [IW-1:0] wb_index;
    logic [1:0]    wb_way;
    logic [IW-1:0] st_index;
    logic [1:0]    st_way;
    logic [1:0]    st_din;
    logic          st_we;
    logic          st_en;
    logic [1:0]    st_dout0, st_dout1, st_dout2, st_dout3;

    logic [1:0]      arr [4][NSET] = '{default: '0};
    logic [1:0]      mdl [4][NSET];
    bit   [1:0]      mrr;
    logic [IW+1:0]   hs_q [$];
    int              n_checks = 0;
    int              n_fail   = 0;

    dcache_state_ctrl #(.IW(IW), .NSET(NSET)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_sec(req_sec), .req_index(req_index), .req_way(req_way),
        .resp_valid(resp_valid), .resp_way(resp_way), .resp_evict(resp_evict),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_index(wb_index), .wb_way(wb_way),
        .st_index(st_index), .st_way(st_way), .st_din(st_din), .st_we(st_we), .st_en(st_en),
        .st_dout0(st_dout0), .st_dout1(st_dout1), .st_dout2(st_dout2), .st_dout3(st_dout3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (st_en && st_we) arr[st_way][st_index] <= st_din;
    end

    assign st_dout0 = arr[0][st_index];
    assign st_dout1 = arr[1][st_index];
    assign st_dout2 = arr[2][st_index];
    assign st_dout3 = arr[3][st_index];

    function automatic int arr_diff();
        int d = 0;
        for (int w = 0; w < 4; w++)
            for (int s = 0; s < NSET; s++)
                if (arr[w][s] !== mdl[w][s]) d++;
        return d;
    endfunction

    // Reference model for FILL / MARK_DIRTY / INVAL outcomes and latencies.
    task automatic model_step(input logic [1:0] op, input logic sec, input logic [IW-1:0] idx,
                              input logic [1:0] way, output int e_lat,
                              output logic [1:0] e_way, output logic e_ev);
        int lo = sec ? 2 : 0;
        e_way = '0;
        e_ev  = 1'b0;
        if (op == 2'b00) begin
            e_lat = 2;
            if (mdl[lo][idx][0] == 1'b0) e_way = 2'(lo);
            else if (mdl[lo+1][idx][0] == 1'b0) e_way = 2'(lo + 1);
            else begin
                e_way    = 2'(lo + int'(mrr[sec]));
                e_ev     = mdl[e_way][idx][1];
                mrr[sec] = !mrr[sec];
            end
            mdl[e_way][idx] = 2'b01;
        end else begin
            e_lat = 1;
            if (way[1] == sec) mdl[way][idx] = (op == 2'b01) ? 2'b11 : 2'b00;
        end
    endtask

    // Issue one request, follow it to resp_valid, serve writebacks after wb_delay cycles.
    task automatic run_op(input logic [1:0] op, input logic sec, input logic [IW-1:0] idx,
                          input logic [1:0] way, input int wb_delay,
                          output int lat, output logic [1:0] rway, output logic rev);
        bit            wb_act = 0;
        int            wb_cnt = 0;
        logic [IW-1:0] wi = '0;
        logic [1:0]    ww = '0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL req_ready_at_issue: got %b want 1", req_ready);
        end
        req_valid = 1'b1; req_op = op; req_sec = sec; req_index = idx; req_way = way;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op = 2'($urandom); req_sec = 1'($urandom);
        req_index = IW'($urandom); req_way = 2'($urandom);
        lat = 0; rway = '0; rev = 1'b0;
        while (lat < BUDGET) begin
            @(negedge clk);
            lat++;
            if (wb_valid === 1'b1) begin
                if (!wb_act) begin
                    wb_act = 1; wb_cnt = 0; wi = wb_index; ww = wb_way;
                    hs_q.push_back({wi, ww});
                end else begin
                    n_checks++;
                    if (wb_index !== wi || wb_way !== ww) begin
                        n_fail++;
                        $display("FAIL wb_stable: got idx=%0d way=%0d want idx=%0d way=%0d",
                                 wb_index, wb_way, wi, ww);
                    end
                end
                wb_cnt++;
                wb_ready = (wb_cnt >= wb_delay);
            end else begin
                wb_act   = 0;
                wb_ready = 1'($urandom);
            end
            if (resp_valid === 1'b1) begin
                rway = resp_way;
                rev  = resp_evict;
                break;
            end
        end
        @(posedge clk); #1;
        wb_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; wb_ready = 1'b0;
        req_op = '0; req_sec = 1'b0; req_index = '0; req_way = '0;
        for (int w = 0; w < 4; w++)
            for (int s = 0; s < NSET; s++) mdl[w][s] = 2'b00;
        mrr = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_req_ready: got %b want 0", req_ready);
        end
        n_checks++;
        if ({resp_valid, resp_way, resp_evict, wb_valid, wb_index, wb_way,
             st_we, st_en, st_index, st_way, st_din} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rv=%b rw=%0d re=%b wv=%b wi=%0d ww=%0d we=%b en=%b si=%0d sw=%0d sd=%0d want all 0",
                     resp_valid, resp_way, resp_evict, wb_valid, wb_index, wb_way,
                     st_we, st_en, st_index, st_way, st_din);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || st_en !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset: got ready=%b en=%b want 1/0", req_ready, st_en);
        end
    endtask

    task automatic test_directed();
        logic [1:0] t_op  [12] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00,
                                  2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00};
        logic       t_sec [12] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 1, 1};
        logic [1:0] t_way [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 3, 0};
        int e_lat, lat;
        logic [1:0] e_way, rway;
        logic e_ev, rev;
        for (int k = 0; k < 12; k++) begin
            model_step(t_op[k], t_sec[k], IW'(3), t_way[k], e_lat, e_way, e_ev);
            run_op(t_op[k], t_sec[k], IW'(3), t_way[k], 1, lat, rway, rev);
            n_checks++;
            if (lat !== e_lat) begin
                n_fail++; $display("FAIL dir_latency[%0d]: got %0d want %0d", k, lat, e_lat);
            end
            if (t_op[k] == 2'b00) begin
                n_checks++;
                if (rway !== e_way || rev !== e_ev) begin
                    n_fail++;
                    $display("FAIL dir_victim[%0d]: got way=%0d evict=%b want way=%0d evict=%b",
                             k, rway, rev, e_way, e_ev);
                end
            end
            n_checks++;
            if (arr_diff() != 0) begin
                n_fail++; $display("FAIL dir_array[%0d]: got %0d differing entries want 0", k, arr_diff());
            end
        end
    endtask

    task automatic test_back_to_back(input int n);
        int e_lat, lat;
        logic [1:0] op, way, e_way, rway;
        logic sec, e_ev, rev;
        logic [IW-1:0] idx;
        for (int k = 0; k < n; k++) begin
            op  = 2'($urandom_range(0, 2));
            sec = 1'($urandom);
            idx = IW'($urandom);
            way = 2'($urandom);
            model_step(op, sec, idx, way, e_lat, e_way, e_ev);
            run_op(op, sec, idx, way, 1, lat, rway, rev);
            n_checks++;
            if (lat !== e_lat) begin
                n_fail++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", k, lat, e_lat);
            end
            if (op == 2'b00) begin
                n_checks++;
                if (rway !== e_way || rev !== e_ev) begin
                    n_fail++;
                    $display("FAIL b2b_victim[%0d]: got way=%0d evict=%b want way=%0d evict=%b",
                             k, rway, rev, e_way, e_ev);
                end
            end
            n_checks++;
            if (arr_diff() != 0) begin
                n_fail++; $display("FAIL b2b_array[%0d]: got %0d differing entries want 0", k, arr_diff());
            end
        end
    endtask

    task automatic test_flush(input logic sec, input int delay);
        logic [IW+1:0] exp_q [$];
        int e_lat = 2 * 2 * NSET;
        int lat;
        logic [1:0] rway;
        logic rev;
        for (int i = 0; i < NSET; i++)
            for (int l = 0; l < 2; l++) begin
                if (mdl[2*sec+l][i] == 2'b11) begin
                    exp_q.push_back({IW'(i), 2'(2*sec+l)});
                    e_lat += delay;
                end
                mdl[2*sec+l][i] = 2'b00;
            end
        hs_q.delete();
        run_op(2'b11, sec, IW'($urandom), 2'($urandom), delay, lat, rway, rev);
        n_checks++;
        if (lat !== e_lat) begin
            n_fail++; $display("FAIL flush%0d_latency: got %0d want %0d", sec, lat, e_lat);
        end
        n_checks++;
        if (hs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL flush%0d_wb_count: got %0d want %0d", sec, hs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[j]) begin
                n_checks++;
                if (hs_q[j] !== exp_q[j]) begin
                    n_fail++;
                    $display("FAIL flush%0d_wb_entry[%0d]: got idx=%0d way=%0d want idx=%0d way=%0d",
                             sec, j, hs_q[j][IW+1:2], hs_q[j][1:0], exp_q[j][IW+1:2], exp_q[j][1:0]);
                end
            end
        end
        n_checks++;
        if (arr_diff() != 0) begin
            n_fail++; $display("FAIL flush%0d_array: got %0d differing entries want 0", sec, arr_diff());
        end
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (resp_valid !== 1'b0) begin
                n_fail++; $display("FAIL flush%0d_single_resp: got resp_valid=%b want 0", sec, resp_valid);
            end
        end
    endtask

    task automatic test_flush_plan();
        int e_lat, lat;
        logic [1:0] e_way, rway;
        logic e_ev, rev;
        model_step(2'b01, 1'b1, IW'(1), 2'd2, e_lat, e_way, e_ev);
        run_op(2'b01, 1'b1, IW'(1), 2'd2, 1, lat, rway, rev);
        model_step(2'b01, 1'b1, IW'(3), 2'd3, e_lat, e_way, e_ev);
        run_op(2'b01, 1'b1, IW'(3), 2'd3, 1, lat, rway, rev);
        test_flush(1'b1, 3);
    endtask

    task automatic test_flush_reset();
        int e_lat, lat, cyc;
        logic [1:0] e_way, rway;
        logic e_ev, rev, seen;
        model_step(2'b00, 1'b1, IW'(0), 2'd0, e_lat, e_way, e_ev);
        run_op(2'b00, 1'b1, IW'(0), 2'd0, 1, lat, rway, rev);
        model_step(2'b00, 1'b1, IW'(3), 2'd0, e_lat, e_way, e_ev);
        run_op(2'b00, 1'b1, IW'(3), 2'd0, 1, lat, rway, rev);
        model_step(2'b01, 1'b1, IW'(2), 2'd3, e_lat, e_way, e_ev);
        run_op(2'b01, 1'b1, IW'(2), 2'd3, 1, lat, rway, rev);
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b11; req_sec = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        seen = 1'b0; cyc = 0;
        while (!seen && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            if (wb_valid === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen || wb_index !== IW'(2) || wb_way !== 2'd3) begin
            n_fail++;
            $display("FAIL abort_wb_target: got seen=%b idx=%0d way=%0d want 1/2/3", seen, wb_index, wb_way);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (wb_valid !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0 || st_we !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got wb_valid=%b ready=%b resp=%b we=%b want 0/1/0/0",
                     wb_valid, req_ready, resp_valid, st_we);
        end
        mdl[2][0] = 2'b00;
        mrr = '0;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (resp_valid !== 1'b0) begin
                n_fail++; $display("FAIL abort_no_resp: got resp_valid=%b want 0", resp_valid);
            end
        end
        n_checks++;
        if (arr_diff() != 0) begin
            n_fail++; $display("FAIL abort_array: got %0d differing entries want 0", arr_diff());
        end
        model_step(2'b00, 1'b1, IW'(3), 2'd0, e_lat, e_way, e_ev);
        run_op(2'b00, 1'b1, IW'(3), 2'd0, 1, lat, rway, rev);
        n_checks++;
        if (lat !== e_lat || rway !== e_way || rev !== e_ev) begin
            n_fail++;
            $display("FAIL post_abort_fill: got lat=%0d way=%0d ev=%b want lat=%0d way=%0d ev=%b",
                     lat, rway, rev, e_lat, e_way, e_ev);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back(60);
        test_flush(1'b0, int'($urandom_range(1, 4)));
        test_flush(1'b1, int'($urandom_range(1, 4)));
        test_flush_plan();
        test_flush_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
